monitor_dbg_capture_ctrl: RTL
=============================

MONITOR_DBG_CAPTURE_CTRL -- requirements
Module: monitor_dbg_capture_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, input sample width; DEPTH, 8, capture FIFO entries (power of two).
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  DATA_W  asynchronous debug input.
- irq  out  1  level interrupt.
REQ-003 Accesses SHALL be valid only with chipselect=1; read and write SHALL NOT be asserted together.

Function
REQ-004 in_port SHALL pass through a 2-flop synchronizer; only the synchronized value is sampled.
REQ-005 Register map SHALL be:
- 0 DATA (R): pop.
- 1 CTRL (RW): bit0 enable, bit1 change_only, bit2 irq_en, bit3 flush (write-1, self-clearing, reads 0).
- 2 PRESCALE (RW): bits[15:0] divisor N.
- 3 STATUS (R/W1C): bits[3:0] count, bit8 empty, bit9 full, bit10 overflow (sticky; writing 1 clears it).
REQ-006 readdata SHALL be updated on the cycle after a read and hold until the next read.
REQ-007 A DATA read SHALL return {valid, 15'b0, sample[15:0]}, with valid=1 iff the FIFO was non-empty on the read cycle. A non-empty read SHALL pop the oldest entry; an empty read SHALL return 0 and not pop.
REQ-008 Prescaler:
- While enable=1, the counter SHALL count 0..N and wrap.
- A sample tick SHALL occur on the cycle the counter equals N, i.e. every N+1 cycles; N=0 samples every cycle.
- While enable=0 the counter SHALL be held at 0.
- A PRESCALE write SHALL also clear the counter.
REQ-009 On a tick, the synchronized sample SHALL be pushed unless change_only=1 and the sample equals last_pushed. The first tick after enable goes 0->1 SHALL always push.
REQ-010 last_pushed SHALL update only on an accepted push.
REQ-011 If the FIFO is full at a tick with no same-cycle pop, the sample SHALL be dropped and overflow set. A same-cycle pop SHALL make room, so the push is accepted.
REQ-012 A same-cycle push and pop on an empty FIFO SHALL return valid=0, and the push SHALL succeed (count becomes 1).
REQ-013 Flush SHALL zero the count and pointers in the write cycle. A same-cycle tick SHALL be discarded without setting overflow. Overflow and last_pushed SHALL be unchanged.
REQ-014 Clearing enable SHALL retain FIFO contents; reads SHALL continue to pop.
REQ-015 irq SHALL equal irq_en AND (count != 0), derived only from registered state.
REQ-016 count SHALL saturate at DEPTH; pointers SHALL wrap modulo DEPTH.

Reset
REQ-017 While reset=1, all of the following SHALL be 0: CTRL, PRESCALE, counter, FIFO pointers, count, overflow, last_pushed, first-sample flag, synchronizer flops, readdata and irq.
REQ-018 Reset SHALL take precedence over all accesses in the same cycle. Assertion mid-capture SHALL discard FIFO contents.

Verification
REQ-019 Benches SHALL cover these scenarios:
- N=3, enable=1, change_only=0, in_port=0x1234 constant: a push every 4 cycles. After 8 pushes STATUS reads full=1, count=8. The next tick sets overflow=1.
- change_only=1, in_port sequence 0xA,0xA,0xB,0xB,0xA over successive ticks (N=0): FIFO holds 0xA,0xB,0xA. DATA reads return 0x8000000A, 0x8000000B, 0x8000000A, then 0x00000000.
- FIFO full, DATA read coincident with tick: read returns the oldest entry, the new sample is accepted, count stays 8, overflow stays 0.
- FIFO empty, N=0, DATA read on the first tick cycle: readdata=0, count=1 next cycle.
- irq_en=1: irq rises the cycle count becomes 1. Flush write -> count=0 and irq=0 next cycle; overflow is unchanged until a STATUS write with bit10=1 clears it.
- reset asserted with count=5, enable=1: the following cycle has count=0, readdata=0, irq=0, CTRL=0, and no pushes until re-enabled.

Source files
------------

// File: rtl/monitor_dbg_capture_ctrl.sv
// Debug input capture: synchronized sampler with prescaler, change filter
// and a small FIFO exposed as an Avalon-MM slave with a level interrupt.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   address[1:0]      word address: 0 DATA, 1 CTRL, 2 PRESCALE, 3 STATUS
//   chipselect/read/write/writedata[31:0]
//                     Avalon-MM slave access
//   readdata[31:0]    registered read data, updated after each read
//   in_port[DATA_W-1:0]  asynchronous debug input
//   irq               irq_en and FIFO not empty
module monitor_dbg_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_PRSC = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic [DATA_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0] last_q, last_d;
  logic              enable_q, enable_d;
  logic              chg_q, chg_d;
  logic              irq_en_q, irq_en_d;
  logic              first_q, first_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       presc_q, presc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_en, rd_en;
  logic wr_ctrl, wr_prsc, wr_stat, rd_data;
  logic flush, tick, empty, full;
  logic pop, want, push;
  logic unused_wd;

  assign unused_wd = ^writedata[31:16];

  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign wr_ctrl = wr_en & (address == A_CTRL);
  assign wr_prsc = wr_en & (address == A_PRSC);
  assign wr_stat = wr_en & (address == A_STAT);
  assign rd_data = rd_en & (address == A_DATA);

  assign flush = wr_ctrl & writedata[3];
  assign tick  = enable_q & (cnt_q == presc_q);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign pop  = rd_data & ~empty;
  // A flush discards a coincident tick entirely.
  assign want = tick & ~flush &
                (~chg_q | first_q | (sync2_q != last_q));
  // A same-cycle pop frees the slot the push needs.
  assign push = want & (~full | pop);

  assign readdata = rdata_q;
  assign irq      = irq_en_q & ~empty;

  always_comb begin
    enable_d = enable_q;
    chg_d    = chg_q;
    irq_en_d = irq_en_q;
    first_d  = first_q;
    ovf_d    = ovf_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    last_d   = last_q;
    rdata_d  = rdata_q;

    if (wr_ctrl) begin
      enable_d = writedata[0];
      chg_d    = writedata[1];
      irq_en_d = writedata[2];
    end

    if (tick & ~flush)
      first_d = 1'b0;
    if (wr_ctrl & writedata[0] & ~enable_q)
      first_d = 1'b1;

    if (wr_prsc)
      presc_d = writedata[15:0];

    if (~enable_q | wr_prsc | tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push)
        wptr_d = wptr_q + AW'(1);
      if (pop)
        rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (push)
      last_d = sync2_q;

    // Setting wins over a coincident clear so no event is lost.
    if (wr_stat & writedata[10])
      ovf_d = 1'b0;
    if (want & full & ~pop)
      ovf_d = 1'b1;

    if (rd_en) begin
      unique case (address)
        A_DATA: begin
          if (empty)
            rdata_d = '0;
          else
            rdata_d = {1'b1, 15'b0, 16'(mem_q[rptr_q])};
        end
        A_CTRL: rdata_d = {29'b0, irq_en_q, chg_q, enable_q};
        A_PRSC: rdata_d = {16'b0, presc_q};
        A_STAT: rdata_d = {21'b0, ovf_q, full, empty,
                           4'b0, 4'(count_q)};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      last_q   <= '0;
      enable_q <= 1'b0;
      chg_q    <= 1'b0;
      irq_en_q <= 1'b0;
      first_q  <= 1'b0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      last_q   <= last_d;
      enable_q <= enable_d;
      chg_q    <= chg_d;
      irq_en_q <= irq_en_d;
      first_q  <= first_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (~reset & push)
      mem_q[wptr_q] <= sync2_q;
  end

endmodule
